csi2_raw12_unpack: RTL and testbench

//  Upstream feeder of the de-Bayer stage: converts the 2-lane CSI-2 RAW12 payload byte stream
//  (16 bit/cycle) into two-pixel words of lane_raw_data_t (2 x 12 bit), one data_valid per word.

---
 rtl/top_pkg.sv | 32 +++
 rtl/raw12_gearbox.sv | 93 +++++++++
 rtl/csi2_raw12_unpack.sv | 161 ++++++++++++++++
 tb/tb_csi2_raw12_unpack.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/top_pkg.sv
// Shared types for the camera front-end: RAW12 pixel/word types, gearbox constants,
// the unpack FSM encoding and the triplet-to-pixel unpack helper.
package top_pkg;

    typedef logic [11:0] raw12_pix_t;

    // Two-pixel word handed to the de-Bayer stage; p1 is the odd column.
    typedef struct packed {
        raw12_pix_t p1;
        raw12_pix_t p0;
    } lane_raw_data_t;

    localparam int RAW12_BYTES_PER_WORD = 3;
    localparam int RAW12_LANE_BYTES     = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } raw12_state_e;

    // b2 carries the four LSBs of both pixels: low nibble for P0, high nibble for P1.
    function automatic lane_raw_data_t raw12_unpack(input logic [7:0] b0,
                                                    input logic [7:0] b1,
                                                    input logic [7:0] b2);
        lane_raw_data_t w;
        w.p0 = {b0, b2[3:0]};
        w.p1 = {b1, b2[7:4]};
        return w;
    endfunction

endpackage

// File: rtl/raw12_gearbox.sv
// RAW12 gearbox: 2 bytes/cycle in, one unpacked two-pixel word out per completed byte triplet.
// word/word_stb are combinational; the caller registers them. clear restarts at residue 0.
module raw12_gearbox
    import top_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [15:0] byte_in,
    output logic [23:0] word,
    output logic        word_stb
);

    logic [1:0]     res_cnt_r;
    logic [7:0]     res0_r;
    logic [7:0]     res1_r;

    logic [1:0]     cnt_eff_s;
    logic [1:0]     cnt_nxt_s;
    logic [7:0]     res0_nxt_s;
    logic [7:0]     res1_nxt_s;
    logic [7:0]     t0_s;
    logic [7:0]     t1_s;
    logic [7:0]     t2_s;
    logic           stb_s;
    lane_raw_data_t word_s;

    // A clear in the same cycle as data makes those bytes the first of the new line.
    assign cnt_eff_s = clear ? 2'd0 : res_cnt_r;

    // Residue bookkeeping and triplet selection for the 0 -> 2 -> 1 -> 0 cycle.
    always_comb begin
        cnt_nxt_s  = cnt_eff_s;
        res0_nxt_s = res0_r;
        res1_nxt_s = res1_r;
        t0_s       = 8'h00;
        t1_s       = 8'h00;
        t2_s       = 8'h00;
        stb_s      = 1'b0;
        if (byte_valid) begin
            case (cnt_eff_s)
                2'd0: begin
                    res0_nxt_s = byte_in[7:0];
                    res1_nxt_s = byte_in[15:8];
                    cnt_nxt_s  = 2'd2;
                end
                2'd2: begin
                    t0_s       = res0_r;
                    t1_s       = res1_r;
                    t2_s       = byte_in[7:0];
                    stb_s      = 1'b1;
                    res0_nxt_s = byte_in[15:8];
                    cnt_nxt_s  = 2'd1;
                end
                2'd1: begin
                    t0_s      = res0_r;
                    t1_s      = byte_in[7:0];
                    t2_s      = byte_in[15:8];
                    stb_s     = 1'b1;
                    cnt_nxt_s = 2'd0;
                end
                default: begin
                    cnt_nxt_s = 2'd0;
                end
            endcase
        end else begin
            cnt_nxt_s = cnt_eff_s;
        end
    end

    // Unpack the selected triplet into two pixels.
    always_comb begin
        word_s = raw12_unpack(t0_s, t1_s, t2_s);
    end

    assign word     = word_s;
    assign word_stb = stb_s;

    // Residue state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cnt_r <= 2'd0;
            res0_r    <= 8'h00;
            res1_r    <= 8'h00;
        end else begin
            res_cnt_r <= cnt_nxt_s;
            res0_r    <= res0_nxt_s;
            res1_r    <= res1_nxt_s;
        end
    end

endmodule

// File: rtl/csi2_raw12_unpack.sv
// CSI-2 RAW12 payload unpacker: line FSM, word counter, framing errors and output registers.
// Build option RAW12_PAT_GEN_EN replaces camera data by a per-line column ramp.
module csi2_raw12_unpack
    import top_pkg::*;
#(
    parameter int LINE_LENGTH = 640
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_start,
    input  logic [15:0] byte_in,
    input  logic        byte_valid,
    output logic [23:0] data_out,
    output logic        data_valid,
    output logic        line_done,
    output logic        err_short,
    output logic        err_long
);

    localparam int CNT_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_LENGTH - 1);

    if ((LINE_LENGTH % 2) != 0) begin : g_bad_line_length
        $error("csi2_raw12_unpack: LINE_LENGTH must be even");
    end

    raw12_state_e     state_r;
    raw12_state_e     state_nxt_s;
    logic [CNT_W-1:0] word_cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             long_seen_r;
    logic             long_seen_nxt_s;
    logic             line_done_nxt_s;
    logic             err_short_nxt_s;
    logic             err_long_nxt_s;

    logic             gb_clear_s;
    logic             gb_valid_s;
    logic [23:0]      gb_word_s;
    logic             gb_stb_s;
    logic [23:0]      word_sel_s;

    logic [23:0]      data_out_r;
    logic             data_valid_r;
    logic             line_done_r;
    logic             err_short_r;
    logic             err_long_r;

    // Bytes reach the gearbox only inside a line, or with the line_start that opens one.
    assign gb_clear_s = line_start;
    assign gb_valid_s = byte_valid && (line_start || (state_r == ST_ACTIVE));

    raw12_gearbox u_gearbox (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (gb_clear_s),
        .byte_valid (gb_valid_s),
        .byte_in    (byte_in),
        .word       (gb_word_s),
        .word_stb   (gb_stb_s)
    );

`ifdef RAW12_PAT_GEN_EN
    logic [11:0] pat_p0_s;
    assign pat_p0_s   = 12'({word_cnt_r, 1'b0});
    assign word_sel_s = {pat_p0_s | 12'd1, pat_p0_s};
`else
    assign word_sel_s = gb_word_s;
`endif

    // Line FSM, word counter and framing-error detection.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = word_cnt_r;
        long_seen_nxt_s = long_seen_r;
        line_done_nxt_s = 1'b0;
        err_short_nxt_s = 1'b0;
        err_long_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (line_start) begin
                    state_nxt_s     = ST_ACTIVE;
                    cnt_nxt_s       = '0;
                    long_seen_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (line_start) begin
                    err_short_nxt_s = 1'b1;
                    cnt_nxt_s       = '0;
                end else if (gb_stb_s) begin
                    if (word_cnt_r == LAST_WORD) begin
                        state_nxt_s     = ST_DONE;
                        cnt_nxt_s       = '0;
                        line_done_nxt_s = 1'b1;
                        long_seen_nxt_s = 1'b0;
                    end else begin
                        cnt_nxt_s = word_cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_nxt_s = word_cnt_r;
                end
            end
            ST_DONE: begin
                if (line_start) begin
                    state_nxt_s     = ST_ACTIVE;
                    cnt_nxt_s       = '0;
                    long_seen_nxt_s = 1'b0;
                end else if (byte_valid && !long_seen_r) begin
                    err_long_nxt_s  = 1'b1;
                    long_seen_nxt_s = 1'b1;
                end else begin
                    long_seen_nxt_s = long_seen_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            word_cnt_r  <= '0;
            long_seen_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            word_cnt_r  <= cnt_nxt_s;
            long_seen_r <= long_seen_nxt_s;
        end
    end

    // Output registers; data_out keeps the last word between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r   <= 24'h000000;
            data_valid_r <= 1'b0;
            line_done_r  <= 1'b0;
            err_short_r  <= 1'b0;
            err_long_r   <= 1'b0;
        end else begin
            data_out_r   <= gb_stb_s ? word_sel_s : data_out_r;
            data_valid_r <= gb_stb_s;
            line_done_r  <= line_done_nxt_s;
            err_short_r  <= err_short_nxt_s;
            err_long_r   <= err_long_nxt_s;
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign line_done  = line_done_r;
    assign err_short  = err_short_r;
    assign err_long   = err_long_r;

endmodule

// File: tb/tb_csi2_raw12_unpack.sv
// Scoreboard bench for csi2_raw12_unpack with LINE_LENGTH=4 and directed byte ramps.
// Define RAW12_PAT_GEN_EN on both bench and RTL to check the column-ramp words.
module tb_csi2_raw12_unpack;

    localparam int LL = 4;

    logic        clk;
    logic        rst_n;
    logic        line_start;
    logic [15:0] byte_in;
    logic        byte_valid;
    logic [23:0] data_out;
    logic        data_valid;
    logic        line_done;
    logic        err_short;
    logic        err_long;

    csi2_raw12_unpack #(.LINE_LENGTH(LL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_start (line_start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .line_done  (line_done),
        .err_short  (err_short),
        .err_long   (err_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] data;
        logic        last;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    logic [23:0] exp_tab [LL];
    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;
    int          short_cnt = 0;
    int          long_cnt  = 0;
    int          long_cyc  = -1;
    int          dv_cnt    = 0;

    // Stimulus-side reference of line progress.
    logic        m_active = 1'b0;
    int          m_vc     = 0;
    int          m_words  = 0;
    logic        m_long   = 1'b0;
    int          exp_long_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on each data_valid and counts error pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_short) short_cnt++;
            if (err_long) begin
                long_cnt++;
                long_cyc = cyc;
            end
            if (data_valid) begin
                dv_cnt++;
                if (sb_q.size() == 0) begin
                    check("unexpected_data_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("data_out", {8'h00, data_out}, {8'h00, e.data});
                    check("line_done", {31'd0, line_done}, {31'd0, e.last});
                    check("data_valid_cycle", cyc, e.due);
                end
            end else begin
                if (line_done) check("line_done_without_data", 32'd1, 32'd0);
                if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("missing_data_valid", cyc, e.due);
                end
            end
        end
    end

    function automatic logic [15:0] bytes_of(input int n);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = 8'(2 * n - 1);
        hi = 8'(2 * n);
        return {hi, lo};
    endfunction

    // One input cycle; also records what the DUT must answer.
    task automatic tick(input logic ls, input logic bv, input logic [15:0] b);
        exp_t e;
        line_start = ls;
        byte_valid = bv;
        byte_in    = b;
        if (ls) begin
            m_active = 1'b1;
            m_vc     = 0;
            m_words  = 0;
            m_long   = 1'b0;
        end
        if (bv && m_active) begin
            if (m_words < LL) begin
                m_vc++;
                if ((m_vc % 3) != 1) begin
                    e.data = exp_tab[m_words];
                    e.last = (m_words == LL - 1);
                    e.due  = cyc + 1;
                    sb_q.push_back(e);
                    m_words++;
                end
            end else if (!m_long) begin
                m_long       = 1'b1;
                exp_long_cyc = cyc + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'($urandom));
    endtask

    task automatic end_scenario(input string name, input int exp_short, input int exp_long);
        idle(3);
        check({name, "_queue_drained"}, sb_q.size(), 32'd0);
        check({name, "_err_short_cnt"}, short_cnt, exp_short);
        check({name, "_err_long_cnt"}, long_cnt, exp_long);
        short_cnt = 0;
        long_cnt  = 0;
    endtask

    initial begin
`ifdef RAW12_PAT_GEN_EN
        exp_tab[0] = 24'h001000; exp_tab[1] = 24'h003002;
        exp_tab[2] = 24'h005004; exp_tab[3] = 24'h007006;
`else
        exp_tab[0] = 24'h020013; exp_tab[1] = 24'h050046;
        exp_tab[2] = 24'h080079; exp_tab[3] = 24'h0B00AC;
`endif
        rst_n      = 1'b0;
        line_start = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 16'h0000;

        // 1: reset with random inputs, then no line_start -> no output
        for (int i = 0; i < 4; i++) begin
            line_start = 1'($urandom);
            byte_valid = 1'($urandom);
            byte_in    = 16'($urandom);
            @(negedge clk);
            check("reset_outputs", {3'd0, data_out, data_valid, line_done, err_short, err_long},
                  32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 16'($urandom));
        check("no_output_before_line_start", dv_cnt, 32'd0);
        end_scenario("s1", 0, 0);

        // 2: back-to-back line
        tick(1'b1, 1'b0, 16'h0000);
        for (int n = 1; n <= 6; n++) tick(1'b0, 1'b1, bytes_of(n));
        end_scenario("s2", 0, 0);

        // 3: gapped line, line_start coincident with the first bytes
        for (int n = 1; n <= 6; n++) begin
            tick(n == 1, 1'b1, bytes_of(n));
            tick(1'b0, 1'b0, 16'($urandom));
        end
        end_scenario("s3", 0, 0);

        // 4: short line then a clean full line
        tick(1'b1, 1'b0, 16'h0000);
        for (int n = 1; n <= 3; n++) tick(1'b0, 1'b1, bytes_of(n));
        tick(1'b1, 1'b0, 16'h0000);
        for (int n = 1; n <= 6; n++) tick(1'b0, 1'b1, bytes_of(n));
        end_scenario("s4", 1, 0);

        // 5: long line, err_long once, nothing more until next line_start
        tick(1'b1, 1'b0, 16'h0000);
        for (int n = 1; n <= 8; n++) tick(1'b0, 1'b1, bytes_of(n));
        for (int n = 0; n < 4; n++) tick(1'b0, 1'b1, 16'($urandom));
        check("s5_err_long_cycle", long_cyc, exp_long_cyc);
        end_scenario("s5", 0, 1);

        // Next line after an overlong one is clean again.
        tick(1'b1, 1'b0, 16'h0000);
        for (int n = 1; n <= 6; n++) tick(1'b0, 1'b1, bytes_of(n));
        end_scenario("s5_next", 0, 0);

        check("total_words", dv_cnt, 32'd22);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
